// File: rtl/uart_tx_fifo_if.sv
// Byte-stream and status bundle between a UART transmitter and its producer.
// Producer drives cfg/valid/data; transmitter returns ready, serial line and status.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_WIDTH-1:0] cfg_div_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic [7:0]           tx_data_i;
  logic                 tx_o;
  logic                 busy_o;
  logic [LW-1:0]        fifo_level_o;

  modport master (
    output cfg_div_i, tx_valid_i, tx_data_i,
    input  tx_ready_o, tx_o, busy_o, fifo_level_o
  );

  modport slave (
    input  cfg_div_i, tx_valid_i, tx_data_i,
    output tx_ready_o, tx_o, busy_o, fifo_level_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8E1 UART transmitter; start bit begins the cycle after the pop, one cycle after the push.
// Backpressure: tx_ready_o = !full; frames chain back to back while the FIFO holds bytes.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 full, empty, push, pop;

  state_t               state, state_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_WIDTH-1:0] div_lat, div_lat_nxt;
  logic                 par, par_nxt;
  logic                 tx_q, tx_nxt;
  logic                 bit_end, load;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = bus.tx_valid_i & ~full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.tx_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      div_lat <= '0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      div_lat <= div_lat_nxt;
      par     <= par_nxt;
      tx_q    <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    div_lat_nxt = div_lat;
    par_nxt     = par;
    pop         = 1'b0;
    load        = 1'b0;
    bit_end     = (div_cnt == '0);

    case (state)
      IDLE: begin
        load = ~empty;
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          div_cnt_nxt = div_lat;
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_cnt_nxt = div_lat;
          if (bit_cnt == 3'd7) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          div_cnt_nxt = div_lat;
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          load      = ~empty;
          state_nxt = IDLE;
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Divider is sampled only here, so mid-frame cfg changes wait for the next frame.
    if (load) begin
      pop         = 1'b1;
      state_nxt   = START;
      shift_nxt   = mem[rd_ptr];
      par_nxt     = ^mem[rd_ptr];
      bit_cnt_nxt = '0;
      div_lat_nxt = bus.cfg_div_i;
      div_cnt_nxt = bus.cfg_div_i;
    end

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx_ready_o   = ~full;
  assign bus.tx_o         = tx_q;
  assign bus.busy_o       = (state != IDLE) | ~empty;
  assign bus.fifo_level_o = level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one 8N1 instance and one 8E1 instance on a shared clock/reset.
// Line samples are taken on the falling edge; index c is the sample after the c-th rising edge.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) ifn ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) ifp ();

  uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16), .PARITY_EN(0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifn.slave)
  );

  uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16), .PARITY_EN(1)) dut_p (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifp.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic       line_s [0:1023];
  logic       rdy_s  [0:1023];
  logic       busy_s [0:1023];
  logic [2:0] lvl_s  [0:1023];
  int         acc_c  [0:15];
  int         nacc;
  logic [7:0] pend [$];

  // Expected line level k cycles into a frame of byte b with bit period d.
  function automatic logic exp_bit(input logic [7:0] b, input int d, input bit pen, input int k);
    int idx;
    idx = k / d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pen && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Mid-bit sampling, like a receiving monitor at matching baud.
  function automatic logic [7:0] decode(input int base, input int d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = line_s[base + (1 + i) * d + d / 2];
    return r;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      ifp.tx_valid_i = v;
      ifp.tx_data_i  = d;
    end else begin
      ifn.tx_valid_i = v;
      ifn.tx_data_i  = d;
    end
  endtask

  // Offers queued bytes and records n falling-edge samples; call at a falling edge.
  task automatic stream(input bit sel, input int n, input int chg_c, input logic [15:0] chg_div);
    logic       vld, rdy_prev;
    logic [7:0] tmp;
    vld = (pend.size() > 0);
    set_in(sel, vld, vld ? pend[0] : 8'h00);
    rdy_prev = sel ? ifp.tx_ready_o : ifn.tx_ready_o;
    nacc = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (vld && rdy_prev) begin
        tmp = pend.pop_front();
        if (nacc < 16) acc_c[nacc] = c;
        nacc++;
      end
      line_s[c] = sel ? ifp.tx_o : ifn.tx_o;
      rdy_s[c]  = sel ? ifp.tx_ready_o : ifn.tx_ready_o;
      busy_s[c] = sel ? ifp.busy_o : ifn.busy_o;
      lvl_s[c]  = sel ? ifp.fifo_level_o : ifn.fifo_level_o;
      if (c == chg_c) begin
        if (sel) ifp.cfg_div_i = chg_div;
        else     ifn.cfg_div_i = chg_div;
      end
      vld = (pend.size() > 0);
      set_in(sel, vld, vld ? pend[0] : 8'h00);
      rdy_prev = sel ? ifp.tx_ready_o : ifn.tx_ready_o;
    end
    set_in(sel, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    n_total++;
    if (ifn.tx_o !== 1'b1 || ifn.tx_ready_o !== 1'b1 || ifn.busy_o !== 1'b0 || ifn.fifo_level_o !== 3'd0) begin
      $display("FAIL reset_values: tx=%b rdy=%b busy=%b lvl=%0d, want 1 1 0 0",
               ifn.tx_o, ifn.tx_ready_o, ifn.busy_o, ifn.fifo_level_o);
    end else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (ifp.tx_o !== 1'b1 || ifp.busy_o !== 1'b0 || ifp.fifo_level_o !== 3'd0) begin
      $display("FAIL reset_release: tx=%b busy=%b lvl=%0d, want 1 0 0", ifp.tx_o, ifp.busy_o, ifp.fifo_level_o);
    end else n_pass++;
  endtask

  task automatic test_single;
    logic [9:0] exp41 = 10'b1010000010;
    int nerr, first;
    @(negedge clk);
    ifn.cfg_div_i = 16'd9;
    pend = '{8'h41};
    stream(1'b0, 102, -1, 16'd0);
    n_total++;
    if (acc_c[0] !== 0 || lvl_s[0] !== 3'd1 || line_s[0] !== 1'b1) begin
      $display("FAIL single_accept: acc=%0d lvl=%0d tx=%b, want 0 1 1", acc_c[0], lvl_s[0], line_s[0]);
    end else n_pass++;
    nerr = 0; first = -1;
    for (int k = 0; k < 100; k++) begin
      if (line_s[1 + k] !== exp41[k / 10]) begin
        nerr++;
        if (first < 0) first = k;
      end
    end
    n_total++;
    if (nerr != 0) $display("FAIL single_frame: %0d bad samples (first %0d), want 0", nerr, first);
    else n_pass++;
    n_total++;
    if (decode(1, 10) !== 8'h41) $display("FAIL single_decode: got %h, want 41", decode(1, 10));
    else n_pass++;
    n_total++;
    if (busy_s[100] !== 1'b1 || busy_s[101] !== 1'b0) begin
      $display("FAIL single_busy_drop: busy@100=%b busy@101=%b, want 1 0", busy_s[100], busy_s[101]);
    end else n_pass++;
  endtask

  task automatic test_fifo_fill;
    int nerr, first, nbad;
    @(negedge clk);
    ifn.cfg_div_i = 16'd1;
    pend = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    stream(1'b0, 125, -1, 16'd0);
    n_total++;
    if (nacc !== 6 || acc_c[4] !== 4 || acc_c[5] !== 22) begin
      $display("FAIL fill_accepts: n=%0d 5th@%0d 6th@%0d, want 6 4 22", nacc, acc_c[4], acc_c[5]);
    end else n_pass++;
    n_total++;
    if (lvl_s[1] !== 3'd1 || lvl_s[4] !== 3'd4 || rdy_s[3] !== 1'b1 || rdy_s[4] !== 1'b0) begin
      $display("FAIL fill_full: lvl1=%0d lvl4=%0d rdy3=%b rdy4=%b, want 1 4 1 0",
               lvl_s[1], lvl_s[4], rdy_s[3], rdy_s[4]);
    end else n_pass++;
    n_total++;
    if (rdy_s[20] !== 1'b0 || rdy_s[21] !== 1'b1 || lvl_s[21] !== 3'd3) begin
      $display("FAIL fill_ready_rise: rdy20=%b rdy21=%b lvl21=%0d, want 0 1 3", rdy_s[20], rdy_s[21], lvl_s[21]);
    end else n_pass++;
    nerr = 0; first = -1; nbad = 0;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 20; k++) begin
        if (line_s[1 + 20 * f + k] !== exp_bit(8'h30 + 8'(f), 2, 1'b0, k)) begin
          nerr++;
          if (first < 0) first = 20 * f + k;
        end
      end
      if (decode(1 + 20 * f, 2) !== 8'h30 + 8'(f)) nbad++;
    end
    n_total++;
    if (nerr != 0) $display("FAIL fill_frames: %0d bad samples (first %0d), want 0", nerr, first);
    else n_pass++;
    n_total++;
    if (nbad != 0) $display("FAIL fill_text: %0d of 6 chars differ from 012345", nbad);
    else n_pass++;
    n_total++;
    if (busy_s[120] !== 1'b1 || busy_s[121] !== 1'b0) begin
      $display("FAIL fill_busy: busy@120=%b busy@121=%b, want 1 0", busy_s[120], busy_s[121]);
    end else n_pass++;
  endtask

  task automatic test_parity;
    int nerr, first;
    @(negedge clk);
    ifp.cfg_div_i = 16'd3;
    pend = '{8'h07, 8'h03};
    stream(1'b1, 90, -1, 16'd0);
    nerr = 0; first = -1;
    for (int k = 0; k < 44; k++) begin
      if (line_s[1 + k] !== exp_bit(8'h07, 4, 1'b1, k)) begin nerr++; if (first < 0) first = k; end
      if (line_s[45 + k] !== exp_bit(8'h03, 4, 1'b1, k)) begin nerr++; if (first < 0) first = 44 + k; end
    end
    n_total++;
    if (nerr != 0) $display("FAIL parity_frames: %0d bad samples (first %0d), want 0", nerr, first);
    else n_pass++;
    n_total++;
    if ({line_s[37], line_s[38], line_s[39], line_s[40]} !== 4'b1111) begin
      $display("FAIL parity_bit_07: got %b%b%b%b, want 1111", line_s[37], line_s[38], line_s[39], line_s[40]);
    end else n_pass++;
    n_total++;
    if ({line_s[81], line_s[82], line_s[83], line_s[84]} !== 4'b0000) begin
      $display("FAIL parity_bit_03: got %b%b%b%b, want 0000", line_s[81], line_s[82], line_s[83], line_s[84]);
    end else n_pass++;
    n_total++;
    if (busy_s[88] !== 1'b1 || busy_s[89] !== 1'b0) begin
      $display("FAIL parity_length: busy@88=%b busy@89=%b, want 1 0", busy_s[88], busy_s[89]);
    end else n_pass++;
  endtask

  task automatic test_div_change;
    int nerr, first;
    @(negedge clk);
    ifn.cfg_div_i = 16'd9;
    pend = '{8'h41, 8'h42};
    stream(1'b0, 302, 20, 16'd19);
    nerr = 0; first = -1;
    for (int k = 0; k < 100; k++)
      if (line_s[1 + k] !== exp_bit(8'h41, 10, 1'b0, k)) begin nerr++; if (first < 0) first = k; end
    n_total++;
    if (nerr != 0) $display("FAIL divchg_current: %0d bad samples (first %0d), want 0", nerr, first);
    else n_pass++;
    nerr = 0; first = -1;
    for (int k = 0; k < 200; k++)
      if (line_s[101 + k] !== exp_bit(8'h42, 20, 1'b0, k)) begin nerr++; if (first < 0) first = k; end
    n_total++;
    if (nerr != 0) $display("FAIL divchg_next: %0d bad samples (first %0d), want 0", nerr, first);
    else n_pass++;
    n_total++;
    if (busy_s[300] !== 1'b1 || busy_s[301] !== 1'b0) begin
      $display("FAIL divchg_busy: busy@300=%b busy@301=%b, want 1 0", busy_s[300], busy_s[301]);
    end else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int nlow, nlvl, nerr;
    @(negedge clk);
    ifn.cfg_div_i = 16'd9;
    pend = '{8'h55, 8'h66, 8'h77};
    stream(1'b0, 31, -1, 16'd0);
    n_total++;
    if (lvl_s[30] !== 3'd2 || line_s[30] !== 1'b0) begin
      $display("FAIL rstmid_setup: lvl=%0d tx=%b, want 2 0", lvl_s[30], line_s[30]);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (ifn.tx_o !== 1'b1 || ifn.fifo_level_o !== 3'd0 || ifn.tx_ready_o !== 1'b1 || ifn.busy_o !== 1'b0) begin
      $display("FAIL rstmid_async: tx=%b lvl=%0d rdy=%b busy=%b, want 1 0 1 0",
               ifn.tx_o, ifn.fifo_level_o, ifn.tx_ready_o, ifn.busy_o);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    stream(1'b0, 150, -1, 16'd0);
    nlow = 0; nlvl = 0;
    for (int c = 0; c < 150; c++) begin
      if (line_s[c] !== 1'b1) nlow++;
      if (lvl_s[c] !== 3'd0 || busy_s[c] !== 1'b0) nlvl++;
    end
    n_total++;
    if (nlow != 0 || nlvl != 0) $display("FAIL rstmid_quiet: %0d non-idle line samples, %0d busy/level samples, want 0 0", nlow, nlvl);
    else n_pass++;
    pend = '{8'h5A};
    stream(1'b0, 102, -1, 16'd0);
    nerr = 0;
    for (int k = 0; k < 100; k++)
      if (line_s[1 + k] !== exp_bit(8'h5A, 10, 1'b0, k)) nerr++;
    n_total++;
    if (nerr != 0 || decode(1, 10) !== 8'h5A) begin
      $display("FAIL rstmid_clean_frame: %0d bad samples, decoded %h, want 0 5a", nerr, decode(1, 10));
    end else n_pass++;
  endtask

  task automatic test_div_zero;
    logic [9:0] exp55 = 10'b1010101010;
    logic [9:0] got;
    @(negedge clk);
    ifn.cfg_div_i = 16'd0;
    pend = '{8'h55};
    stream(1'b0, 12, -1, 16'd0);
    for (int k = 0; k < 10; k++) got[k] = line_s[1 + k];
    n_total++;
    if (got !== exp55) $display("FAIL div0_bits: got %b, want %b (bit0 first on line)", got, exp55);
    else n_pass++;
    n_total++;
    if (line_s[0] !== 1'b1 || line_s[11] !== 1'b1 || busy_s[10] !== 1'b1 || busy_s[11] !== 1'b0) begin
      $display("FAIL div0_edges: tx0=%b tx11=%b busy10=%b busy11=%b, want 1 1 1 0",
               line_s[0], line_s[11], busy_s[10], busy_s[11]);
    end else n_pass++;
  endtask

  initial begin
    ifn.cfg_div_i = 16'd9; ifn.tx_valid_i = 1'b0; ifn.tx_data_i = 8'h00;
    ifp.cfg_div_i = 16'd3; ifp.tx_valid_i = 1'b0; ifp.tx_data_i = 8'h00;
    repeat (2) @(negedge clk);
    test_reset;
    test_single;
    test_fifo_fill;
    test_parity;
    test_div_change;
    test_reset_midframe;
    test_div_zero;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synthesizable UART transmitter with a small byte FIFO and a runtime baud divider. It drives the serial line consumed by the UART simulation monitor in the testbench, so the SoC peripheral path and bench print path can be checked end to end. Bytes arrive over a valid/ready handshake, are buffered, and are serialized as 8N1 frames, or 8E1 when parity is enabled.

## Interface
- FIFO_DEPTH, 4: byte FIFO entries, power of two, ≥2
- DIV_WIDTH, 16: width of the baud divider
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- cfg_div_i  in  DIV_WIDTH  bit period minus one, in clk_i cycles (D = cfg_div_i + 1)
- tx_valid_i  in  1  byte on tx_data_i is valid
- tx_ready_o  out  1  FIFO can accept a byte (= !full)
- tx_data_i  in  8  byte to send
- tx_o  out  1  serial line, idles high
- busy_o  out  1  FIFO not empty or frame in progress
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Push: on a clock edge with tx_valid_i & tx_ready_o, the FIFO writes tx_data_i.
- The FIFO has no bypass path. A byte is always written before it can be popped.
- A push and a pop in the same cycle are legal. The level is unchanged.
- Push is impossible when the FIFO is full because ready is low. Pop is impossible when it is empty.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_o=1. If the FIFO is not empty: pop the head into the shift register, latch cfg_div_i into the divider, go to START.
- START: tx_o=0 for D cycles, then go to DATA.
- DATA: tx_o=shift[0]. Shift right every D cycles. A 3-bit counter counts 8 bits, LSB first. After bit 7, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: tx_o = XOR of the 8 data bits (even parity) for D cycles, then go to STOP.
- STOP: tx_o=1 for D cycles. At the end of STOP:
  - if the FIFO is not empty, pop and go directly to START, with no idle gap and the divider relatched;
  - else go to IDLE.
- Divider: a DIV_WIDTH-bit down-counter loaded with the latched divider at every bit boundary. The bit ends when the count is 0.
- cfg_div_i=0 gives D=1, which is legal.
- A change on cfg_div_i during a frame has no effect until the next frame starts.
- tx_o is driven from a flop (no combinational glitches).
- busy_o = (state != IDLE) | (level != 0).

## Timing
- Reset values: tx_o=1, tx_ready_o=1, busy_o=0, fifo_level_o=0, state=IDLE, FIFO pointers 0.
- Reset applies immediately (asynchronously) and aborts any frame in flight. tx_o returns high at once and FIFO contents are discarded.
- Latency from an idle, empty FIFO:
  - byte accepted at edge E0;
  - pop and START entry at E1;
  - tx_o falls after E1.
- Frame length is 10·D cycles, or 11·D with parity.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- fifo_level_o and tx_ready_o update on the edge after a push or pop.
- tx_ready_o rises the cycle after the pop that frees an entry.

## Test plan
- 0x41, cfg_div_i=9, PARITY_EN=0: tx_o is low for 10 cycles starting the cycle after E1, then bits 1,0,0,0,0,0,1,0 for 10 cycles each, then stop high for 10. The monitor at matching baud prints "A". busy_o drops 100 cycles after E1.
- FIFO fill, FIFO_DEPTH=4, tx_valid_i held high with bytes 0x30..0x35 from idle:
  - 5 bytes are accepted (the first pops at E1);
  - tx_ready_o goes low after the 5th;
  - the 6th is accepted the cycle after the second pop;
  - the line shows contiguous frames "012345" with no gaps.
- PARITY_EN=1, cfg_div_i=3, byte 0x07: the parity bit is 1 (4 cycles) and the frame is 44 cycles. For byte 0x03 the parity bit is 0.
- cfg_div_i changed from 9 to 19 mid-frame: the current frame keeps 10-cycle bits and the next queued frame uses 20-cycle bits.
- rst_i pulsed mid-DATA with 2 bytes queued: tx_o=1 and fifo_level_o=0 immediately. No further frames are sent after release, and the next push sends a clean frame.
- cfg_div_i=0: 0x55 is sent as 10 single-cycle bits, 0,1,0,1,0,1,0,1,0,1.
